// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : M-stage data memory responder with fixed wait-state latency
// Rev 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] C_WINIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [AW-1:0]   idx_q;
  logic            mis_q;
  logic            store_q;
  logic [31:0]     data_q;
  logic [31:0]     rdata_q;
  logic            misalign_q;
  logic [31:0]     load_cnt_q;
  logic [31:0]     store_cnt_q;
  logic [31:0]     mem [DEPTH];

  logic            w_req;
  logic            w_stall;
  logic            w_commit;
  logic            w_in_idle;
  logic [AW-1:0]   w_idx;
  logic            w_mis;
  logic            w_store;
  logic [31:0]     w_wdata;
  logic            w_unused_addr;

  assign w_req         = MemReadM | MemWriteM;
  assign w_unused_addr = ^ALUOutM[31:AW+2];

  // With LATENCY==1 the access commits straight out of IDLE, before the
  // latches hold anything, so the live inputs are used in that state.
  assign w_in_idle = (state_q == S_IDLE);
  assign w_idx     = w_in_idle ? ALUOutM[AW+1:2]       : idx_q;
  assign w_mis     = w_in_idle ? (ALUOutM[1:0] != 2'b00) : mis_q;
  assign w_store   = w_in_idle ? MemWriteM             : store_q;
  assign w_wdata   = w_in_idle ? WriteDataM            : data_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    w_stall  = 1'b0;
    w_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          wcnt_d  = C_WINIT;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
          end else begin
            state_d  = S_DONE;
            w_commit = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        wcnt_d  = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          state_d  = S_DONE;
          w_commit = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 4'd0;
      idx_q       <= '0;
      mis_q       <= 1'b0;
      store_q     <= 1'b0;
      data_q      <= 32'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (w_in_idle && w_req) begin
        idx_q   <= ALUOutM[AW+1:2];
        mis_q   <= (ALUOutM[1:0] != 2'b00);
        store_q <= MemWriteM;
        data_q  <= WriteDataM;
      end
      if (w_commit) begin
        misalign_q <= w_mis;
        if (!w_store) begin
          rdata_q <= w_mis ? 32'd0 : mem[w_idx];
        end
        if (!w_mis) begin
          if (w_store) store_cnt_q <= store_cnt_q + 32'd1;
          else         load_cnt_q  <= load_cnt_q + 32'd1;
        end
      end else begin
        misalign_q <= 1'b0;
      end
    end
  end

  // RAM is never cleared; reset gating keeps an aborted store from landing.
  always_ff @(posedge clk) begin
    if (w_commit && w_store && !w_mis && !reset) begin
      mem[w_idx] <= w_wdata;
    end
  end

  assign StallM     = w_stall & ~reset;
  assign ReadDataM  = rdata_q;
  assign MisalignM  = misalign_q;
  assign LoadCount  = load_cnt_q;
  assign StoreCount = store_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed bench for dmem_responder (LATENCY 2 and 1)
// Rev 1.0
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        rd, wr;
  logic [31:0] addr, wdata;

  logic        rd0, wr0, rd1, wr1;
  logic [31:0] rdata0, rdata1, lc0, lc1, sc0, sc1;
  logic        stall0, stall1, mis0, mis1;

  logic [31:0] o_rdata, o_lc, o_sc;
  logic        o_stall, o_mis;

  int n_tests;
  int n_fail;

  assign rd0 = rd & ~sel;
  assign wr0 = wr & ~sel;
  assign rd1 = rd & sel;
  assign wr1 = wr & sel;

  assign o_rdata = sel ? rdata1 : rdata0;
  assign o_lc    = sel ? lc1    : lc0;
  assign o_sc    = sel ? sc1    : sc0;
  assign o_stall = sel ? stall1 : stall0;
  assign o_mis   = sel ? mis1   : mis0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .MemReadM(rd0), .MemWriteM(wr0),
    .ALUOutM(addr), .WriteDataM(wdata), .ReadDataM(rdata0), .StallM(stall0),
    .MisalignM(mis0), .LoadCount(lc0), .StoreCount(sc0)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .MemReadM(rd1), .MemWriteM(wr1),
    .ALUOutM(addr), .WriteDataM(wdata), .ReadDataM(rdata1), .StallM(stall1),
    .MisalignM(mis1), .LoadCount(lc1), .StoreCount(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the selected DUT idle; returns
  // just after the edge that leaves DONE, request already withdrawn.
  task automatic do_access(input string tag, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input int lat, input logic exp_mis,
                           input logic [31:0] exp_rd, input logic [31:0] exp_lc,
                           input logic [31:0] exp_sc);
    rd = r; wr = w; addr = a; wdata = d;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, ".stall"}, 32'(o_stall), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, ".done_stall"}, 32'(o_stall), 32'd0);
    check({tag, ".mis"}, 32'(o_mis), 32'(exp_mis));
    check({tag, ".rdata"}, o_rdata, exp_rd);
    check({tag, ".lc"}, o_lc, exp_lc);
    check({tag, ".sc"}, o_sc, exp_sc);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", 32'(o_stall), 32'd0);
    check("rst.rdata", o_rdata, 32'd0);
    check("rst.mis", 32'(o_mis), 32'd0);
    check("rst.lc", o_lc, 32'd0);
    check("rst.sc", o_sc, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // store then load
    do_access("sw8", 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 2, 1'b0, 32'd0, 32'd0, 32'd1);
    do_access("lw8", 1'b1, 1'b0, 32'h8, 32'd0, 2, 1'b0, 32'hDEADBEEF, 32'd1, 32'd1);

    // misaligned load
    do_access("lw6", 1'b1, 1'b0, 32'h6, 32'd0, 2, 1'b1, 32'd0, 32'd1, 32'd1);
    check("lw6.mis_after", 32'(o_mis), 32'd0);

    // address wrap
    do_access("sw100", 1'b0, 1'b1, 32'h100, 32'h1234, 2, 1'b0, 32'd0, 32'd1, 32'd2);
    do_access("lw0", 1'b1, 1'b0, 32'h0, 32'd0, 2, 1'b0, 32'h1234, 32'd2, 32'd2);

    // read and write together is a store
    do_access("rw4", 1'b1, 1'b1, 32'h4, 32'h55, 2, 1'b0, 32'h1234, 32'd2, 32'd3);
    do_access("lw4", 1'b1, 1'b0, 32'h4, 32'd0, 2, 1'b0, 32'h55, 32'd3, 32'd3);

    // reset in WAIT aborts the store
    do_access("swC", 1'b0, 1'b1, 32'hC, 32'h77, 2, 1'b0, 32'h55, 32'd3, 32'd4);
    rd = 1'b0; wr = 1'b1; addr = 32'hC; wdata = 32'hAA;
    @(negedge clk);
    check("abort.stall0", 32'(o_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort.stall1", 32'(o_stall), 32'd1);
    reset = 1'b1;
    #1;
    check("abort.stall_rel", 32'(o_stall), 32'd0);
    check("abort.sc", o_sc, 32'd0);
    check("abort.rdata", o_rdata, 32'd0);
    wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_access("lwC", 1'b1, 1'b0, 32'hC, 32'd0, 2, 1'b0, 32'h77, 32'd1, 32'd0);

    // back-to-back loads at LATENCY=1
    sel = 1'b1;
    #1;
    do_access("l1.sw10", 1'b0, 1'b1, 32'h10, 32'h11111111, 1, 1'b0, 32'd0, 32'd0, 32'd1);
    do_access("l1.sw14", 1'b0, 1'b1, 32'h14, 32'h22222222, 1, 1'b0, 32'd0, 32'd0, 32'd2);
    do_access("l1.lw10", 1'b1, 1'b0, 32'h10, 32'd0, 1, 1'b0, 32'h11111111, 32'd1, 32'd2);
    do_access("l1.lw14", 1'b1, 1'b0, 32'h14, 32'd0, 1, 1'b0, 32'h22222222, 32'd2, 32'd2);
    @(negedge clk);
    check("l1.idle_stall", 32'(o_stall), 32'd0);
    check("l1.hold_rdata", o_rdata, 32'h22222222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
